sobel_mag_post: RTL
===================

// Module: sobel_mag_post
// PURPOSE
//  Post-processing stage directly downstream of the Sobel convolution stage.
//  Consumes its 18-bit |G| stream (valid-qualified, no backpressure).
//  Functions:
//   - blanks the invalid border window pixels
//   - scales and saturates the magnitude to the 12-bit display pixel width
//   - optionally binarises against a threshold
//   - reports the per-frame peak magnitude for software auto-gain
//  Output feeds the VGA/SDRAM write path.
// PARAMETERS
//  IMG_WIDTH   640  active pixels per line (>=3)
//  IMG_HEIGHT  480  active lines per frame (>=3)
//  IN_WIDTH    18   input magnitude width
//  OUT_WIDTH   12   output pixel width
// PORTS
//  i_clk          in   1          clock
//  i_rst_n        in   1          reset, asynchronous, active-low
//  i_val_valid    in   1          input beat valid
//  i_val          in   IN_WIDTH   unsigned magnitude from convolution stage
//  i_sof          in   1          start of frame; qualified by i_val_valid; marks pixel (0,0)
//  i_shift        in   3          right-shift applied before saturation (0..7)
//  i_binary       in   1          1 = binary output mode
//  i_thresh       in   OUT_WIDTH  binarisation threshold
//  o_pix_valid    out  1          output pixel valid
//  o_pix          out  OUT_WIDTH  processed pixel
//  o_frame_peak   out  IN_WIDTH   max unshifted |G| over non-border pixels of last frame
//  o_peak_valid   out  1          1-cycle pulse when o_frame_peak updates
// BEHAVIOUR
//  Reset:
//   - all outputs 0; col/row counters 0; running max 0; pipeline valids 0.
//  Position tracking:
//   - col/row advance only on beats with i_val_valid.
//   - col wraps at IMG_WIDTH-1 and increments row; row wraps at IMG_HEIGHT-1.
//   - A beat with i_sof=1 is treated as (0,0); counters continue from there.
//   - i_sof without i_val_valid is ignored.
//  Border:
//   - border = (row<2) || (col<2), evaluated on the beat's own position.
//   - A border pixel outputs 0 and is excluded from the peak.
//  Pipeline (fixed latency 2 cycles; no stalls; gaps in valid pass through):
//   - S1 registers: mag_sh = i_val >> i_shift; border flag; last flag; and
//     i_binary/i_thresh. Controls are sampled per beat, so a mid-stream change
//     affects only beats accepted after the change.
//   - S2 registers: sat = (mag_sh > 2^OUT_WIDTH-1) ? all-ones : mag_sh[OUT_WIDTH-1:0].
//     - o_pix = border ? 0 : (binary ? ((sat >= thresh) ? all-ones : 0) : sat).
//   - o_pix_valid = i_val_valid delayed 2 cycles.
//   - o_pix holds its last value when o_pix_valid=0.
//  Peak:
//   - run_max updates on non-border valid beats, unsigned compare.
//   - On the last pixel (row=IMG_HEIGHT-1, col=IMG_WIDTH-1):
//     - o_frame_peak <= max(run_max, that pixel if non-border)
//     - run_max <= 0
//     - o_peak_valid pulses coincident with that pixel's o_pix_valid.
//   - An i_sof beat arriving before the last pixel aborts the frame:
//     - run_max restarts from this beat (0 if it is border, which it always is)
//     - no peak pulse for the aborted frame; o_frame_peak holds its old value.
//  Simultaneous i_sof and last-pixel position: i_sof wins (pixel is (0,0)).
//  Reset mid-frame: everything returns to reset values; the next frame must begin with i_sof.
// STRUCTURE
//  Shared package edge_pkg:
//   - PIX_W=12, MAG_W=18 constants
//   - typedef pix_t, mag_t
//   - typedef struct packed {valid, border, last, mag_sh, binary, thresh} post_s1_t
//  Sub-module pixel_pos_counter:
//   - params W, H
//   - in: clk, rst_n, adv, sof
//   - out: col, row, is_border, is_last
//   - reusable by other window stages
// TESTING
//  Border (W=4,H=4): frame of values 1..16, shift 0
//   -> outputs 0 except indices (2,2)=11, (2,3)=12, (3,2)=15, (3,3)=16; latency exactly 2.
//  Saturation (interior pixels):
//   - i_val=262143, shift=0 -> 4095
//   - 262143, shift=6 -> 4095
//   - 8192, shift=2 -> 2048
//   - 8191, shift=1 -> 4095
//  Binary (interior): thresh=100, inputs 99, 100, 5000 -> 0, 4095, 4095; i_binary=0 -> 99, 100, 4095.
//  Peak: 9000 at border (0,3), 5000 at (2,2), rest 1
//   -> o_frame_peak=5000, single o_peak_valid with last o_pix_valid; next frame starts from 0.
//  Abort: i_sof at (3,2) mid-frame -> no o_peak_valid; the following complete frame reports the correct peak.
//  Robustness:
//   - random 0-3 cycle valid gaps -> identical o_pix sequence
//   - i_rst_n low mid-frame -> all outputs 0 next cycle; recovery on the next i_sof.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types for the edge-detection post-processing path: pixel and
// magnitude widths plus the first-stage pipeline record.
package edge_pkg;

  localparam int PIX_W = 12;
  localparam int MAG_W = 18;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [MAG_W-1:0] mag_t;

  typedef struct packed {
    logic valid;
    logic border;
    logic last;
    mag_t mag_sh;
    logic binary;
    pix_t thresh;
  } post_s1_t;

endpackage

// File: rtl/pixel_pos_counter.sv
// Raster position tracker for valid-qualified pixel streams. The reported
// position is the position of the beat currently on the input: a start-of-
// frame beat is forced to (0,0), and the counters continue from there.
module pixel_pos_counter #(
  parameter int W  = 640,
  parameter int H  = 480,
  parameter int CW = $clog2(W),
  parameter int RW = $clog2(H)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_adv,
  input  logic          i_sof,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_is_border,
  output logic          o_is_last
);

  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  assign o_col       = i_sof ? '0 : r_col;
  assign o_row       = i_sof ? '0 : r_row;
  assign o_is_border = (o_row < RW'(2)) || (o_col < CW'(2));
  assign o_is_last   = (o_row == ROW_LAST) && (o_col == COL_LAST);

  // Step to the position of the next beat, wrapping column then row.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_adv) begin
      if (o_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (o_row == ROW_LAST) ? '0 : o_row + 1'b1;
      end else begin
        r_col <= o_col + 1'b1;
        r_row <= o_row;
      end
    end
  end

endmodule

// File: rtl/sobel_mag_post.sv
// Post-processing of the Sobel |G| stream: border blanking, shift and
// saturate to display width, optional binarisation, and per-frame peak
// reporting. Fixed two-cycle latency, no backpressure.
module sobel_mag_post
  import edge_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int IN_WIDTH   = MAG_W,
  parameter int OUT_WIDTH  = PIX_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_val_valid,
  input  logic [IN_WIDTH-1:0]  i_val,
  input  logic                 i_sof,
  input  logic [2:0]           i_shift,
  input  logic                 i_binary,
  input  logic [OUT_WIDTH-1:0] i_thresh,
  output logic                 o_pix_valid,
  output logic [OUT_WIDTH-1:0] o_pix,
  output logic [IN_WIDTH-1:0]  o_frame_peak,
  output logic                 o_peak_valid
);

  localparam pix_t PIX_MAX = '1;

  // Clamp a shifted magnitude into the display pixel range.
  function automatic pix_t sat_pix(input mag_t m);
    return (m > mag_t'(PIX_MAX)) ? PIX_MAX : m[PIX_W-1:0];
  endfunction

  // Final pixel value: blank borders, then threshold or pass the clamp.
  function automatic pix_t post_pix(input post_s1_t s);
    pix_t v;
    v = sat_pix(s.mag_sh);
    if (s.border)
      return '0;
    if (s.binary)
      return (v >= s.thresh) ? PIX_MAX : '0;
    return v;
  endfunction

  mag_t     w_mag_p0;
  logic     w_sof_p0;
  logic     w_border_p0;
  logic     w_last_p0;
  mag_t     w_cand_p0;
  mag_t     r_run_max;
  mag_t     r_peak_cand;
  post_s1_t r_s1_p1;

  assign w_mag_p0 = mag_t'(i_val);
  assign w_sof_p0 = i_sof & i_val_valid;

  pixel_pos_counter #(
    .W (IMG_WIDTH),
    .H (IMG_HEIGHT)
  ) u_pos (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_adv       (i_val_valid),
    .i_sof       (w_sof_p0),
    .o_col       (),
    .o_row       (),
    .o_is_border (w_border_p0),
    .o_is_last   (w_last_p0)
  );

  assign w_cand_p0 = (!w_border_p0 && (w_mag_p0 > r_run_max)) ? w_mag_p0 : r_run_max;

  // Running maximum per frame; a start-of-frame beat discards any partial frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run_max   <= '0;
      r_peak_cand <= '0;
    end else if (i_val_valid) begin
      if (w_sof_p0) begin
        r_run_max <= w_border_p0 ? '0 : w_mag_p0;
      end else if (w_last_p0) begin
        r_peak_cand <= w_cand_p0;
        r_run_max   <= '0;
      end else begin
        r_run_max <= w_cand_p0;
      end
    end
  end

  // ---- stage 0 -> 1: shift, border/last flags, per-beat controls ----
  // Capture the beat and the controls that apply to it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_p1 <= '0;
    end else begin
      r_s1_p1.valid <= i_val_valid;
      if (i_val_valid) begin
        r_s1_p1.border <= w_border_p0;
        r_s1_p1.last   <= w_last_p0 & ~w_sof_p0;
        r_s1_p1.mag_sh <= w_mag_p0 >> i_shift;
        r_s1_p1.binary <= i_binary;
        r_s1_p1.thresh <= pix_t'(i_thresh);
      end
    end
  end

  // ---- stage 1 -> 2: saturate/binarise, publish pixel and frame peak ----
  // Produce the output pixel; pixel holds between beats, peak updates on the last pixel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pix_valid  <= 1'b0;
      o_pix        <= '0;
      o_frame_peak <= '0;
      o_peak_valid <= 1'b0;
    end else begin
      o_pix_valid  <= r_s1_p1.valid;
      o_peak_valid <= r_s1_p1.valid & r_s1_p1.last;
      if (r_s1_p1.valid)
        o_pix <= OUT_WIDTH'(post_pix(r_s1_p1));
      if (r_s1_p1.valid && r_s1_p1.last)
        o_frame_peak <= IN_WIDTH'(r_peak_cand);
    end
  end

endmodule
